// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit
`timescale 1ns/1ps
package lsu_pkg;
   localparam int X_LEN          = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int OFF_W          = $clog2(BYTES_PER_WORD);
   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RMW_WR = 2'b01,
      RESP   = 2'b10
   } state_e;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load lane select/extend and sub-word store merge into an old word
`timescale 1ns/1ps
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]       i_size,
   input  logic             i_unsigned,
   input  logic [OFF_W-1:0] i_off,
   input  logic [X_LEN-1:0] i_old,
   input  logic [X_LEN-1:0] i_wdata,
   output logic [X_LEN-1:0] o_load,
   output logic [X_LEN-1:0] o_merged
);
   function automatic logic [X_LEN-1:0] load_ext(logic [X_LEN-1:0] w, logic [1:0] sz, logic [OFF_W-1:0] off, logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> {off, 3'b000});
      h = off[1] ? w[31:16] : w[15:0];
      return (sz == SZ_B) ? {{24{~uns & b[7]}}, b} : (sz == SZ_H) ? {{16{~uns & h[15]}}, h} : w;
   endfunction
   function automatic logic [X_LEN-1:0] merge(logic [X_LEN-1:0] old, logic [X_LEN-1:0] wd, logic [1:0] sz, logic [OFF_W-1:0] off);
      logic [4:0]       sh;
      logic [X_LEN-1:0] m;
      sh = (sz == SZ_B) ? {off, 3'b000} : {off[1], 4'b0000};
      m  = ((sz == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      return (sz == SZ_W) ? wd : (old & ~m) | ((wd << sh) & m);
   endfunction
   // pure lane steering, no state
   always_comb begin
      o_load   = load_ext(i_old, i_size, i_off, i_unsigned);
      o_merged = merge(i_old, i_wdata, i_size, i_off);
   end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit with alignment check and read-modify-write sub-word stores
`timescale 1ns/1ps
module lsu
   import lsu_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_we_i,
   input  logic [1:0]       req_size_i,
   input  logic             req_unsigned_i,
   input  logic [X_LEN-1:0] req_addr_i,
   input  logic [X_LEN-1:0] req_wdata_i,
   output logic             resp_valid_o,
   output logic             resp_err_o,
   output logic [X_LEN-1:0] resp_rdata_o,
   output logic             mem_we_o,
   output logic [X_LEN-1:0] mem_addr_o,
   output logic [X_LEN-1:0] mem_wdata_o,
   input  logic [X_LEN-1:0] mem_rdata_i
);
   state_e           r_state;
   logic             r_err;
   logic [X_LEN-1:0] r_rdata;
   logic [X_LEN-1:0] r_addr;
   logic [X_LEN-1:0] r_wdata;
   logic             w_idle;
   logic             w_acc;
   logic             w_err;
   logic             w_word_st;
   logic             w_sub_st;
   logic             w_rmw;
   logic [X_LEN-1:0] w_waddr;
   logic [X_LEN-1:0] w_load;
   logic [X_LEN-1:0] w_merged;

   assign w_idle    = r_state == IDLE;
   assign w_rmw     = r_state == RMW_WR;
   assign w_acc     = w_idle & req_valid_i;
   assign w_err     = (req_size_i == 2'b11) | ((req_size_i == SZ_H) & req_addr_i[0]) | ((req_size_i == SZ_W) & (req_addr_i[1:0] != 2'b00));
   assign w_word_st = req_we_i & (req_size_i == SZ_W) & ~w_err;
   assign w_sub_st  = req_we_i & (req_size_i != SZ_W) & ~w_err;
   assign w_waddr   = {req_addr_i[X_LEN-1:2], 2'b00};

   assign req_ready_o  = w_idle;
   assign resp_valid_o = r_state == RESP;
   assign resp_err_o   = r_err;
   assign resp_rdata_o = r_rdata;
   assign mem_we_o     = ~rst_i & (w_rmw | (w_acc & w_word_st));
   assign mem_addr_o   = w_rmw ? r_addr : w_waddr;
   assign mem_wdata_o  = w_rmw ? r_wdata : req_wdata_i;

   lsu_lane_align u_align (
      .i_size     (req_size_i),
      .i_unsigned (req_unsigned_i),
      .i_off      (req_addr_i[OFF_W-1:0]),
      .i_old      (mem_rdata_i),
      .i_wdata    (req_wdata_i),
      .o_load     (w_load),
      .o_merged   (w_merged)
   );

   // request FSM: accept in IDLE, optional RMW write cycle, one-cycle response
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_state <= IDLE;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else
         case (r_state)
            IDLE:
               if (req_valid_i) begin
                  r_err   <= w_err;
                  r_rdata <= (w_err | req_we_i) ? '0 : w_load;
                  r_addr  <= w_waddr;
                  r_wdata <= w_merged;
                  r_state <= w_sub_st ? RMW_WR : RESP;
               end
            RMW_WR:
               r_state <= RESP;
            RESP: begin
               r_state <= IDLE;
               r_err   <= 1'b0;
               r_rdata <= '0;
            end
            default:
               r_state <= IDLE;
         endcase
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized scoreboard bench for lsu against a byte-level memory model
`timescale 1ns/1ps
module tb_lsu;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        resp_valid_o, resp_err_o;
   logic [31:0] resp_rdata_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   typedef struct {bit we; bit [1:0] sz; bit uns; bit [31:0] addr; bit [31:0] wd;} req_t;
   typedef struct {bit err; bit [31:0] rd; int cyc;} rsp_t;
   typedef struct {bit [31:0] a; bit [31:0] d; int cyc;} wr_t;

   req_t      stim[$];
   rsp_t      rq[$];
   wr_t       wq[$];
   bit [31:0] mem[0:1023];
   bit [31:0] ref_mem[0:1023];
   int        cyc = 0;
   int        n_chk = 0;
   int        n_fail = 0;
   rsp_t      me;
   wr_t       mw;

   lsu dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   always @(posedge clk_i) if (mem_we_o) mem[mem_addr_o[11:2]] = mem_wdata_o;
   assign mem_rdata_i = mem[mem_addr_o[11:2]];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit [7:0] get_b(bit [31:0] a);
      return 8'(ref_mem[a[11:2]] >> (8 * a[1:0]));
   endfunction

   function automatic void put_b(bit [31:0] a, bit [7:0] v);
      ref_mem[a[11:2]][8 * a[1:0] +: 8] = v;
   endfunction

   function automatic req_t mk(bit we, bit [1:0] sz, bit uns, bit [31:0] addr, bit [31:0] wd);
      req_t r;
      r.we = we; r.sz = sz; r.uns = uns; r.addr = addr; r.wd = wd;
      return r;
   endfunction

   task automatic drive(req_t r);
      req_valid_i = 1'b1; req_we_i = r.we; req_size_i = r.sz;
      req_unsigned_i = r.uns; req_addr_i = r.addr; req_wdata_i = r.wd;
   endtask

   // called in the cycle the DUT is ready: the request is accepted at the next edge
   task automatic issue(req_t r);
      int        nb;
      bit [31:0] v;
      rsp_t      e;
      wr_t       w;
      nb = (r.sz == 2'd0) ? 1 : (r.sz == 2'd1) ? 2 : 4;
      v = 0;
      drive(r);
      e.err = (r.sz == 2'd3) || (r.addr % nb != 0);
      e.rd = 0;
      e.cyc = cyc + ((!e.err && r.we && nb < 4) ? 2 : 1);
      if (!e.err && r.we) begin
         for (int i = 0; i < nb; i++) put_b(r.addr + i, 8'(r.wd >> (8 * i)));
         w.a = {r.addr[31:2], 2'b00};
         w.d = ref_mem[r.addr[11:2]];
         w.cyc = cyc + ((nb < 4) ? 1 : 0);
         wq.push_back(w);
      end else if (!e.err) begin
         for (int i = 0; i < nb; i++) v |= 32'(get_b(r.addr + i)) << (8 * i);
         if (!r.uns && nb < 4 && v[8 * nb - 1]) v |= 32'hFFFF_FFFF << (8 * nb);
         e.rd = v;
      end
      rq.push_back(e);
   endtask

   task automatic run_stream();
      int   wait_n;
      req_t r;
      wait_n = 0;
      while (stim.size() > 0) begin
         @(posedge clk_i); #1;
         if (req_ready_o) begin
            wait_n = 0;
            if ($urandom_range(0, 4) == 0) req_valid_i = 1'b0;
            else begin
               r = stim.pop_front();
               issue(r);
            end
         end else begin
            wait_n++;
            if (wait_n > 8) begin
               n_fail++;
               $display("FAIL ready_timeout: got ready=0 for %0d cycles expected ready=1", wait_n);
               $fatal(1, "ready timeout");
            end
            drive(mk(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom));
         end
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && (rq.size() + wq.size()) > 0; k++) @(posedge clk_i);
      #1;
      chk("drain_pending", 32'(rq.size() + wq.size()), 32'd0);
   endtask

   // monitor: pops expected responses and memory writes whenever the DUT presents them
   always @(negedge clk_i) if (!rst_i) begin
      if (resp_valid_o) begin
         if (rq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL resp_unexpected: got resp_valid=1 expected none (cycle %0d)", cyc);
         end else begin
            me = rq.pop_front();
            chk("resp_err", 32'(resp_err_o), 32'(me.err));
            chk("resp_rdata", resp_rdata_o, me.rd);
            chk("resp_cycle", 32'(cyc), 32'(me.cyc));
            chk("ready_in_resp", 32'(req_ready_o), 32'd0);
         end
      end
      if (mem_we_o) begin
         if (wq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL write_unexpected: got mem_we=1 addr %h expected none (cycle %0d)", mem_addr_o, cyc);
         end else begin
            mw = wq.pop_front();
            chk("wr_addr", mem_addr_o, mw.a);
            chk("wr_data", mem_wdata_o, mw.d);
            chk("wr_cycle", 32'(cyc), 32'(mw.cyc));
         end
      end
   end

   initial begin
      int nmis;
      bit [1:0] sz;
      bit [31:0] a;
      req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_unsigned_i = 0;
      req_addr_i = 0; req_wdata_i = 0;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[32'h100 >> 2] = 32'h8899_AABB; ref_mem[32'h100 >> 2] = 32'h8899_AABB;
      mem[32'h200 >> 2] = 32'hDEAD_BEEF; ref_mem[32'h200 >> 2] = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_ready", 32'(req_ready_o), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("rst_resp_err", 32'(resp_err_o), 32'd0);
      chk("rst_resp_rdata", resp_rdata_o, 32'd0);
      chk("rst_mem_we", 32'(mem_we_o), 32'd0);
      rst_i = 1'b0;

      stim.push_back(mk(0, 2'd0, 0, 32'h102, 0));
      stim.push_back(mk(0, 2'd0, 1, 32'h102, 0));
      stim.push_back(mk(1, 2'd1, 0, 32'h202, 32'h5555_1234));
      stim.push_back(mk(0, 2'd2, 0, 32'h200, 0));
      stim.push_back(mk(1, 2'd2, 0, 32'h300, 32'hCAFE_F00D));
      stim.push_back(mk(0, 2'd2, 0, 32'h300, 0));
      stim.push_back(mk(0, 2'd2, 0, 32'h401, 0));
      stim.push_back(mk(0, 2'd1, 1, 32'h403, 0));
      stim.push_back(mk(0, 2'd3, 0, 32'h404, 0));
      stim.push_back(mk(1, 2'd3, 0, 32'h408, 32'h1111_1111));
      stim.push_back(mk(1, 2'd2, 0, 32'h40A, 32'h2222_2222));
      stim.push_back(mk(1, 2'd1, 0, 32'h40D, 32'h3333_3333));
      for (int i = 0; i < 120; i++) begin
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a = $urandom_range(0, 4095);
         if ($urandom_range(0, 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
         stim.push_back(mk(1'($urandom), sz, 1'($urandom), a, $urandom));
      end
      run_stream();
      drain();

      @(posedge clk_i); #1;
      chk("pre_rst_ready", 32'(req_ready_o), 32'd1);
      drive(mk(1, 2'd0, 0, 32'h501, 32'h0000_005A));
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      chk("rmw_we_before_rst", 32'(mem_we_o), 32'd1);
      rst_i = 1'b1;
      #1;
      chk("rmw_we_in_rst", 32'(mem_we_o), 32'd0);
      chk("resp_valid_in_rst", 32'(resp_valid_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("ready_after_rst", 32'(req_ready_o), 32'd1);
      chk("mem_after_rst", mem[32'h500 >> 2], ref_mem[32'h500 >> 2]);
      repeat (4) @(posedge clk_i);

      stim.push_back(mk(0, 2'd0, 1, 32'h501, 0));
      stim.push_back(mk(0, 2'd2, 0, 32'h500, 0));
      stim.push_back(mk(1, 2'd0, 0, 32'h503, 32'h0000_0080));
      stim.push_back(mk(0, 2'd0, 0, 32'h503, 0));
      run_stream();
      drain();

      nmis = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] != ref_mem[i]) nmis++;
      chk("mem_final_mismatches", 32'(nmis), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the pipeline processor's memory-access stage, directly upstream of the data memory. Accepts one load or store request at a time from the execute stage and checks alignment. It steers byte and halfword data onto the word-wide memory port, sign- or zero-extends load results, and performs read-modify-write for sub-word stores, because the data memory has only a whole-word write enable.

## Interface
- X_LEN, 32, data and address width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr_i  in  X_LEN  byte address.
- req_wdata_i  in  X_LEN  store data, right-aligned (the byte is in [7:0], the half in [15:0]).
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_err_o  out  1  misaligned or illegal-size request; qualified by resp_valid_o.
- resp_rdata_o  out  X_LEN  extended load data; 0 for stores and errors.
- mem_we_o  out  1  data-memory write enable.
- mem_addr_o  out  X_LEN  word address as a byte address; [1:0] always 00.
- mem_wdata_o  out  X_LEN  word written to memory.
- mem_rdata_i  in  X_LEN  memory read data, combinational from mem_addr_o.

## Operation
- FSM states:
  - IDLE: req_ready_o=1.
  - RMW_WR: sub-word store write cycle.
  - RESP: completion cycle.
- Accept: a request is accepted when req_valid_i && req_ready_o in IDLE. The request fields are only sampled in that cycle.
- Error check: a request is an error if size=11, or half with addr[0]=1, or word with addr[1:0]≠00.
  - On error: no memory access, mem_we_o stays 0, go to RESP with err=1.
- Load:
  - In the accept cycle, mem_addr_o = {addr[31:2],2'b00}.
  - Select the byte lane from addr[1:0], or the half lane from addr[1].
  - Extend per req_unsigned_i, register the result, go to RESP.
- Word store: in the accept cycle drive mem_we_o=1 with mem_wdata_o=req_wdata_i, then go to RESP.
- Sub-word store:
  - Accept cycle: read the old word.
  - Merge the new byte/half into its lane and register the merged word plus the address, then go to RMW_WR.
  - RMW_WR: drive mem_we_o=1 with the registered address and merged word, then go to RESP.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. There is no response back-pressure.
- In IDLE with no accept: mem_we_o=0. mem_addr_o follows req_addr_i word-aligned (harmless read).

## Timing
- Reset values: FSM=IDLE, req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_we_o=0, internal registers 0.
- Latencies from accept edge to resp_valid_o:
  - load: 1 cycle
  - word store: 1 cycle
  - sub-word store: 2 cycles
  - error: 1 cycle
- Throughput:
  - One request per 2 cycles for loads and word stores; one per 3 for sub-word stores.
  - req_ready_o is 0 in RMW_WR and RESP.
- Store/load ordering: a load accepted after a store observes the stored value. The write has completed by the time the unit is ready again.
- Reset asserted mid-operation: immediate return to IDLE. A pending RMW write is dropped (mem_we_o=0 combinationally during reset) and no response is issued.
- req_valid_i while not ready: the request is ignored, and the upstream stage holds it.

## Structure
- Package lsu_pkg:
  - size enum (SZ_B, SZ_H, SZ_W)
  - FSM state enum (IDLE, RMW_WR, RESP)
  - constant BYTES_PER_WORD=4
- Sub-module lsu_lane_align (combinational), with two functions:
  - load lane select and extension
  - store lane merge with an old word

  Instantiated once. The FSM and registers stay in lsu.

## Test plan
- Memory word 0x100 = 0x8899AABB; load byte signed at 0x102 -> resp_rdata_o=0xFFFFFF99 one cycle after accept. The same access unsigned -> 0x00000099.
- Store half 0x1234 to 0x202 over 0xDEADBEEF -> mem_we_o high exactly in the RMW_WR cycle with mem_wdata_o=0x1234BEEF. resp_valid_o arrives 2 cycles after accept, and req_ready_o is low for 2 cycles.
- Store word 0xCAFEF00D to 0x300, then load word 0x300 at the first ready cycle -> resp_rdata_o=0xCAFEF00D.
- Load word at 0x401, and a half at 0x403 -> resp_err_o=1, resp_rdata_o=0, mem_we_o never asserted; size=11 also errors.
- Assert rst_i during RMW_WR of a byte store to 0x500 -> mem_we_o drops immediately, memory is unchanged, and there is no resp_valid_o. After release, req_ready_o=1.
- Hold req_valid_i high with different requests back-to-back -> only requests seen while req_ready_o=1 are executed, in order, one response each.
